// File: rtl/apb_master_bridge.sv
// apb_master_bridge: APB master that turns driver-side read/write requests into APB transfers,
// with back-to-back chaining and an abort when a slave stalls for TIMEOUT access cycles.
module apb_master_bridge #(
    parameter int AW      = 9,
    parameter int DW      = 8,
    parameter int TIMEOUT = 16
) (
    input  logic          pclk,
    input  logic          presetn,
    input  logic          transfer,
    input  logic          READ_WRITE,
    input  logic [AW-1:0] apb_write_paddr,
    input  logic [DW-1:0] apb_write_data,
    input  logic [AW-1:0] apb_read_paddr,
    output logic [DW-1:0] apb_read_data_out,
    output logic          apb_slverr_out,
    output logic [AW-1:0] paddr,
    output logic [DW-1:0] pwdata,
    output logic          pwrite,
    output logic          psel1,
    output logic          psel2,
    output logic          penable,
    input  logic [DW-1:0] prdata,
    input  logic          pready,
    input  logic          pslverr
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [1:0]    state;
    logic [CW-1:0] wait_cnt;
    logic          done, capture, timeout;

    assign done    = state == ACCESS && pready;
    assign timeout = state == ACCESS && !pready && wait_cnt == CW'(TIMEOUT - 1);
    assign capture = transfer && (state == IDLE || done);
    // selects decode from the registered address so they can never both be high
    assign psel1   = state != IDLE && !paddr[AW-1];
    assign psel2   = state != IDLE && paddr[AW-1];
    assign penable = state == ACCESS;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state             <= IDLE;
            wait_cnt          <= '0;
            paddr             <= '0;
            pwdata            <= '0;
            pwrite            <= 1'b0;
            apb_read_data_out <= '0;
            apb_slverr_out    <= 1'b0;
        end else begin
            if (capture) begin
                pwrite <= !READ_WRITE;
                paddr  <= READ_WRITE ? apb_read_paddr : apb_write_paddr;
                if (!READ_WRITE) pwdata <= apb_write_data;
            end
            if (done) begin
                apb_slverr_out <= pslverr;
                if (!pwrite) apb_read_data_out <= prdata;
            end
            if (timeout) apb_slverr_out <= 1'b1;
            if (state == SETUP) wait_cnt <= '0;
            else if (state == ACCESS && !pready) wait_cnt <= wait_cnt + 1'b1;
            state <= capture ? SETUP : state == SETUP ? ACCESS : (done || timeout) ? IDLE : state;
        end
    end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a transaction-level model of the bridge.
module tb_apb_master_bridge;
    localparam int AW = 9, DW = 8, TIMEOUT = 16;

    logic          pclk = 0, presetn = 0;
    logic          transfer = 0, READ_WRITE = 0;
    logic [AW-1:0] apb_write_paddr = 0, apb_read_paddr = 0;
    logic [DW-1:0] apb_write_data = 0, prdata = 0;
    logic          pready = 1, pslverr = 0;
    logic [DW-1:0] apb_read_data_out, pwdata;
    logic [AW-1:0] paddr;
    logic          apb_slverr_out, pwrite, psel1, psel2, penable;

    apb_master_bridge #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .pclk(pclk), .presetn(presetn), .transfer(transfer), .READ_WRITE(READ_WRITE),
        .apb_write_paddr(apb_write_paddr), .apb_write_data(apb_write_data),
        .apb_read_paddr(apb_read_paddr), .apb_read_data_out(apb_read_data_out),
        .apb_slverr_out(apb_slverr_out), .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
        .psel1(psel1), .psel2(psel2), .penable(penable), .prdata(prdata),
        .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    int passed = 0, total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Transaction-level model: the current request, how far into it we are, and the latched results.
    bit          m_busy = 0, m_in_access = 0;
    int          m_waits = 0;
    bit          m_write = 0;
    logic [AW-1:0] m_addr = 0;
    logic [DW-1:0] m_wdata = 0, m_rdata = 0;
    bit          m_err = 0;

    task automatic m_take();
        m_busy      = 1;
        m_in_access = 0;
        m_write     = !READ_WRITE;
        m_addr      = READ_WRITE ? apb_read_paddr : apb_write_paddr;
        if (!READ_WRITE) m_wdata = apb_write_data;
    endtask

    always @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            m_busy = 0; m_in_access = 0; m_waits = 0; m_write = 0;
            m_addr = 0; m_wdata = 0; m_rdata = 0; m_err = 0;
        end else if (!m_busy) begin
            if (transfer) m_take();
        end else if (!m_in_access) begin
            m_in_access = 1;
            m_waits = 0;
        end else if (pready) begin
            if (!m_write) m_rdata = prdata;
            m_err = pslverr;
            if (transfer) m_take();
            else m_busy = 0;
        end else begin
            m_waits++;
            if (m_waits == TIMEOUT) begin
                m_busy = 0;
                m_err  = 1;
            end
        end
    end

    always @(negedge pclk) begin
        check("paddr", 32'(paddr), 32'(m_addr));
        check("pwdata", 32'(pwdata), 32'(m_wdata));
        check("pwrite", 32'(pwrite), 32'(m_write));
        check("psel1", 32'(psel1), 32'(m_busy && !m_addr[AW-1]));
        check("psel2", 32'(psel2), 32'(m_busy && m_addr[AW-1]));
        check("penable", 32'(penable), 32'(m_busy && m_in_access));
        check("rdata_out", 32'(apb_read_data_out), 32'(m_rdata));
        check("slverr_out", 32'(apb_slverr_out), 32'(m_err));
        check("psel_exclusive", 32'(psel1 && psel2), 32'(0));
        check("penable_needs_psel", 32'(penable && !(psel1 || psel2)), 32'(0));
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    initial begin
        #3;
        check("reset_psel1", 32'(psel1), 0);
        check("reset_paddr", 32'(paddr), 0);
        check("reset_slverr", 32'(apb_slverr_out), 0);
        tick(); tick();
        presetn = 1;
        tick();
        check("idle_no_start", 32'(psel1 || psel2), 0);

        // write 0x0A5 <- 0x3C, no wait
        transfer = 1; READ_WRITE = 0; apb_write_paddr = 9'h0A5; apb_write_data = 8'h3C; pready = 1;
        tick();
        check("wr_setup_psel1", 32'(psel1), 1);
        check("wr_setup_pwrite", 32'(pwrite), 1);
        check("wr_setup_penable", 32'(penable), 0);
        check("wr_setup_paddr", 32'(paddr), 32'h0A5);
        check("wr_setup_pwdata", 32'(pwdata), 32'h3C);
        transfer = 0;
        tick();
        check("wr_access_penable", 32'(penable), 1);
        tick();
        check("wr_idle_psel", 32'(psel1 || psel2), 0);
        check("wr_slverr", 32'(apb_slverr_out), 0);

        // read 0x1F0 from slave 2 with 3 wait states
        transfer = 1; READ_WRITE = 1; apb_read_paddr = 9'h1F0; pready = 0; prdata = 8'h7E;
        tick();
        check("rd_setup_psel2", 32'(psel2), 1);
        check("rd_setup_psel1", 32'(psel1), 0);
        check("rd_setup_pwdata_kept", 32'(pwdata), 32'h3C);
        transfer = 0;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("rd_wait_penable", 32'(penable), 1);
            tick();
        end
        check("rd_4th_access", 32'(penable), 1);
        pready = 1;
        tick();
        check("rd_done_idle", 32'(penable || psel2), 0);
        check("rd_data", 32'(apb_read_data_out), 32'h7E);

        // back-to-back write 0x010 then read 0x110
        transfer = 1; READ_WRITE = 0; apb_write_paddr = 9'h010; apb_write_data = 8'h55;
        tick();
        READ_WRITE = 1; apb_read_paddr = 9'h110; prdata = 8'hA1;
        tick();
        check("b2b_access1_psel1", 32'(psel1 && penable), 1);
        check("b2b_inputs_ignored", 32'(paddr), 32'h010);
        tick();
        check("b2b_setup2_psel2", 32'(psel2), 1);
        check("b2b_setup2_penable", 32'(penable), 0);
        check("b2b_setup2_paddr", 32'(paddr), 32'h110);
        transfer = 0;
        tick();
        check("b2b_access2", 32'(psel2 && penable), 1);
        tick();
        check("b2b_rdata", 32'(apb_read_data_out), 32'hA1);

        // timeout: pready low for TIMEOUT access cycles
        transfer = 1; READ_WRITE = 1; apb_read_paddr = 9'h005; pready = 0; prdata = 8'hEE;
        tick();
        transfer = 0;
        tick();
        for (int i = 1; i < TIMEOUT; i++) tick();
        check("to_last_access", 32'(penable), 1);
        tick();
        check("to_idle", 32'(psel1 || penable), 0);
        check("to_slverr", 32'(apb_slverr_out), 1);
        check("to_rdata_kept", 32'(apb_read_data_out), 32'hA1);

        // slave error on a read still returns data
        transfer = 1; READ_WRITE = 1; apb_read_paddr = 9'h033; pready = 1; pslverr = 1; prdata = 8'h99;
        tick();
        transfer = 0;
        tick(); tick();
        check("err_slverr", 32'(apb_slverr_out), 1);
        check("err_rdata", 32'(apb_read_data_out), 32'h99);
        pslverr = 0;

        // reset in the middle of a stalled access
        transfer = 1; READ_WRITE = 0; apb_write_paddr = 9'h1AB; apb_write_data = 8'h77; pready = 0;
        tick();
        transfer = 0;
        tick(); tick();
        presetn = 0;
        #1;
        check("rst_async_penable", 32'(penable), 0);
        check("rst_async_psel", 32'(psel1 || psel2), 0);
        check("rst_async_paddr", 32'(paddr), 0);
        check("rst_async_pwdata", 32'(pwdata), 0);
        check("rst_async_pwrite", 32'(pwrite), 0);
        check("rst_async_rdata", 32'(apb_read_data_out), 0);
        check("rst_async_slverr", 32'(apb_slverr_out), 0);
        tick(); tick();
        presetn = 1;
        tick();
        check("rst_release_idle", 32'(psel1 || psel2), 0);

        // randomized traffic with periodic stall windows and one mid-run reset
        for (int i = 0; i < 3000; i++) begin
            transfer        = ($urandom % 4) != 0;
            READ_WRITE      = $urandom % 2;
            apb_write_paddr = AW'($urandom);
            apb_read_paddr  = AW'($urandom);
            apb_write_data  = DW'($urandom);
            prdata          = DW'($urandom);
            pslverr         = ($urandom % 8) == 0;
            pready          = (i % 250 < 30) ? 1'b0 : (($urandom % 3) != 0);
            presetn         = !(i >= 1500 && i < 1503);
            tick();
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/apb_master_bridge.md
APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 SHALL have parameter: AW, 9, address width in bits; bit AW-1 selects the slave.
REQ-002 SHALL have parameter: DW, 8, data width in bits.
REQ-003 SHALL have parameter: TIMEOUT, 16, maximum ACCESS wait cycles with pready low before abort.
REQ-004 SHALL have port: pclk  input  1  single clock; all flops on rising edge.
REQ-005 SHALL have port: presetn  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port: transfer  input  1  request valid from driver side.
REQ-007 SHALL have port: READ_WRITE  input  1  1 = read, 0 = write.
REQ-008 SHALL have port: apb_write_paddr  input  AW  write address.
REQ-009 SHALL have port: apb_write_data  input  DW  write data.
REQ-010 SHALL have port: apb_read_paddr  input  AW  read address.
REQ-011 SHALL have port: apb_read_data_out  output  DW  last completed read data.
REQ-012 SHALL have port: apb_slverr_out  output  1  error status of last completed transfer.
REQ-013 SHALL have port: paddr  output  AW  APB address.
REQ-014 SHALL have port: pwdata  output  DW  APB write data.
REQ-015 SHALL have port: pwrite  output  1  APB direction; 1 = write.
REQ-016 SHALL have port: psel1  output  1  slave 1 select.
REQ-017 SHALL have port: psel2  output  1  slave 2 select.
REQ-018 SHALL have port: penable  output  1  APB access phase.
REQ-019 SHALL have port: prdata  input  DW  muxed slave read data.
REQ-020 SHALL have port: pready  input  1  slave ready.
REQ-021 SHALL have port: pslverr  input  1  slave error.

Function
REQ-022 SHALL implement a registered FSM with states IDLE, SETUP, ACCESS.
REQ-023 In IDLE with transfer=1: SHALL register pwrite=!READ_WRITE, paddr from apb_read_paddr (read) or apb_write_paddr (write), pwdata=apb_write_data (write only; unchanged on read), then go to SETUP next cycle.
REQ-024 In IDLE with transfer=0: SHALL stay in IDLE; psel1=psel2=penable=0.
REQ-025 In SETUP: SHALL drive psel1=!paddr[AW-1] and psel2=paddr[AW-1] with penable=0, then go to ACCESS unconditionally after exactly one cycle.
REQ-026 In ACCESS: SHALL hold psel, penable=1, paddr, pwdata and pwrite stable until completion.
REQ-027 Completion SHALL occur in ACCESS when pready=1.
REQ-028 On completion of a read: SHALL register apb_read_data_out=prdata; otherwise apb_read_data_out holds its value.
REQ-029 On every completion: SHALL register apb_slverr_out=pslverr.
REQ-030 After completion: SHALL go to SETUP if transfer=1, capturing the new request as in REQ-023 (back-to-back, no IDLE cycle); otherwise go to IDLE.
REQ-031 SHALL keep a wait counter, cleared on entry to ACCESS and incremented each ACCESS cycle with pready=0.
REQ-032 When the wait counter reaches TIMEOUT with pready still 0: SHALL abort to IDLE, set apb_slverr_out=1, and leave apb_read_data_out unchanged.
REQ-033 Minimum transfer latency SHALL be 2 cycles (SETUP + ACCESS) from leaving IDLE; each pready-low cycle in ACCESS SHALL add exactly one cycle.
REQ-034 psel1 and psel2 SHALL never be 1 simultaneously.
REQ-035 penable SHALL be 1 only when psel1 or psel2 is 1.
REQ-036 Input changes during SETUP/ACCESS SHALL be ignored until the next capture point.

Reset
REQ-037 On presetn=0, asynchronously and including mid-transfer: SHALL force state=IDLE, wait counter=0, psel1=psel2=penable=pwrite=0, paddr=0, pwdata=0, apb_read_data_out=0, apb_slverr_out=0.
REQ-038 After presetn rises: SHALL start no transfer before the first rising pclk edge that samples transfer=1.

Verification
REQ-039 Write, no wait: AW=9, write 0x0A5 data 0x3C, pready=1 -> SETUP with psel1=1, pwrite=1, penable=0, then ACCESS with penable=1; IDLE next; apb_slverr_out=0.
REQ-040 Read slave 2 with 3 wait states: read 0x1F0, prdata=0x7E at pready -> psel2=1, ACCESS lasts 4 cycles, then apb_read_data_out=0x7E.
REQ-041 Back-to-back: write 0x010 followed by read 0x110 with transfer held high -> second SETUP immediately after first ACCESS with no IDLE cycle; psel moves 1->2.
REQ-042 Timeout: pready held 0 for 16 ACCESS cycles -> return to IDLE, apb_slverr_out=1, apb_read_data_out unchanged.
REQ-043 Slave error: read with pslverr=1 at completion -> apb_slverr_out=1 and apb_read_data_out=prdata.
REQ-044 Reset mid-ACCESS: presetn dropped during wait -> all outputs 0 immediately (before next edge), FSM in IDLE.
